// File: rtl/jet_reg_pkg.sv
// jet_reg_pkg: shared constants and helpers for the jet controller register bank.
//   JET_AW / JET_DW   default bus address / data widths
//   REG_*             register offsets (from the window base) of the jet controller map
//   in_window()       overflow-safe address window test
package jet_reg_pkg;

    localparam int unsigned JET_AW = 16;
    localparam int unsigned JET_DW = 16;

    localparam int unsigned REG_STATUS  = 0;
    localparam int unsigned REG_NRESET  = 1;
    localparam int unsigned REG_JETNUM  = 2;
    localparam int unsigned REG_STADDR  = 3;
    localparam int unsigned REG_DATAROW = 4;
    localparam int unsigned REG_DATACOL = 5;

    // True when base <= addr < base + n. The offset is taken only after addr >= base is known,
    // so a window near the top of the address space never wraps. Addresses up to 32 bits.
    function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base,
                                       input int unsigned n);
        if (addr < base) begin
            return 1'b0;
        end
        return (addr - base) < n;
    endfunction

endpackage

// File: rtl/jet_reg_rd_pipe.sv
// jet_reg_rd_pipe: LAT-stage read-return pipeline (valid / data / error).
//   clk_i, reset_i          clock, asynchronous active-high reset
//   valid_i, data_i, err_i  read result presented in the request cycle
//   valid_o, data_o, err_o  the same result LAT cycles later; data/err hold between valids
module jet_reg_rd_pipe #(
    parameter int unsigned DW  = 16,
    parameter int unsigned LAT = 1
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          valid_i,
    input  logic [DW-1:0] data_i,
    input  logic          err_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    output logic          err_o
);

    logic [LAT-1:0] vld_q;
    logic [LAT-1:0] err_q;
    logic [DW-1:0]  dat_q [LAT];

    // Payload stages load only with a valid so the output holds its last read value.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            vld_q <= '0;
            err_q <= '0;
            for (int s = 0; s < LAT; s++) begin
                dat_q[s] <= '0;
            end
        end else begin
            vld_q[0] <= valid_i;
            if (valid_i) begin
                dat_q[0] <= data_i;
                err_q[0] <= err_i;
            end
            for (int s = 1; s < LAT; s++) begin
                vld_q[s] <= vld_q[s-1];
                if (vld_q[s-1]) begin
                    dat_q[s] <= dat_q[s-1];
                    err_q[s] <= err_q[s-1];
                end
            end
        end
    end

    assign valid_o = vld_q[LAT-1];
    assign data_o  = dat_q[LAT-1];
    assign err_o   = err_q[LAT-1];

endmodule

// File: rtl/jet_reg_bank.sv
// jet_reg_bank: NREG x DW control/status register window at BASE_ADDR for the jet controller.
//   clk_i, reset_i                     clock, asynchronous active-high reset
//   set_wr_en/_addr/_data              host write port (one write per strobe)
//   set_rd_en/_addr                    host read request (one per cycle, fully pipelined)
//   set_rd_data/_data_en/_err          read return, RD_LAT (1 or 2) cycles after the request
//   reg_q, reg_wr_stb                  live register values and per-register update strobes
//   ro_din                             status inputs for read-only registers (RO_MASK)
//   commit_i                           shadow commit strobe
// Optional feature macro JET_REG_BANK_SHADOW_EN: writable, non-pulse registers get a shadow
// copy written by the bus; commit_i copies all shadows to the live values at once.
module jet_reg_bank
    import jet_reg_pkg::*;
#(
    parameter int unsigned          DW         = JET_DW,
    parameter int unsigned          AW         = JET_AW,
    parameter int unsigned          NREG       = 8,
    parameter logic [AW-1:0]        BASE_ADDR  = 'h0010,
    parameter int unsigned          RD_LAT     = 1,
    parameter logic [NREG-1:0]      RO_MASK    = '0,
    parameter logic [NREG-1:0]      PULSE_MASK = '0,
    parameter logic [NREG*DW-1:0]   RST_VAL    = '0
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 set_wr_en,
    input  logic [AW-1:0]        set_wr_addr,
    input  logic [DW-1:0]        set_wr_data,
    input  logic                 set_rd_en,
    input  logic [AW-1:0]        set_rd_addr,
    output logic [DW-1:0]        set_rd_data,
    output logic                 set_rd_data_en,
    output logic                 set_rd_err,
    output logic [NREG*DW-1:0]   reg_q,
    output logic [NREG-1:0]      reg_wr_stb,
    input  logic [NREG*DW-1:0]   ro_din,
    input  logic                 commit_i
);

    if (!(RD_LAT inside {1, 2})) begin : g_bad_lat
        $error("jet_reg_bank: RD_LAT must be 1 or 2");
    end

    logic            wr_in_win;
    logic            rd_in_win;
    logic [AW-1:0]   wr_off;
    logic [AW-1:0]   rd_off;
    logic [NREG-1:0] wr_hit;
    logic [NREG-1:0] stb_d;
    logic [NREG-1:0] stb_q;
    logic [DW-1:0]   rd_val [NREG];
    logic [DW-1:0]   rd_mux;

    // One-hot decode; writes to read-only registers never hit.
    always_comb begin
        wr_off    = set_wr_addr - BASE_ADDR;
        wr_in_win = in_window(32'(set_wr_addr), 32'(BASE_ADDR), NREG);
        for (int k = 0; k < NREG; k++) begin
            wr_hit[k] = set_wr_en && wr_in_win && (wr_off == AW'(k)) && !RO_MASK[k];
        end
    end

    for (genvar k = 0; k < NREG; k++) begin : g_reg
        localparam logic [DW-1:0] RstK = RST_VAL[k*DW +: DW];

        if (RO_MASK[k]) begin : g_ro
            assign reg_q[k*DW +: DW] = ro_din[k*DW +: DW];
            assign rd_val[k]         = ro_din[k*DW +: DW];
            assign stb_d[k]          = 1'b0;
        end else if (PULSE_MASK[k]) begin : g_pulse
            logic [DW-1:0] val_q;
            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) begin
                    val_q <= RstK;
                end else begin
                    val_q <= wr_hit[k] ? set_wr_data : RstK;
                end
            end
            assign reg_q[k*DW +: DW] = val_q;
            assign rd_val[k]         = val_q;
            assign stb_d[k]          = wr_hit[k];
        end else begin : g_rw
`ifdef JET_REG_BANK_SHADOW_EN
            logic [DW-1:0] sh_q;
            logic [DW-1:0] sh_d;
            logic [DW-1:0] val_q;
            // A write in the commit cycle is folded into the commit through sh_d.
            assign sh_d = wr_hit[k] ? set_wr_data : sh_q;
            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) begin
                    sh_q  <= RstK;
                    val_q <= RstK;
                end else begin
                    sh_q <= sh_d;
                    if (commit_i) begin
                        val_q <= sh_d;
                    end
                end
            end
            assign reg_q[k*DW +: DW] = val_q;
            assign rd_val[k]         = sh_q;
            assign stb_d[k]          = commit_i && (sh_d != val_q);
`else
            logic [DW-1:0] val_q;
            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) begin
                    val_q <= RstK;
                end else if (wr_hit[k]) begin
                    val_q <= set_wr_data;
                end
            end
            assign reg_q[k*DW +: DW] = val_q;
            assign rd_val[k]         = val_q;
            assign stb_d[k]          = wr_hit[k];
`endif
        end
    end

    // Slices of ro_din for writable registers, RO bits of wr_hit and (without shadows)
    // commit_i are intentionally left unused.
    logic unused_ok;
    assign unused_ok = ^{commit_i, ro_din, wr_hit};

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            stb_q <= '0;
        end else begin
            stb_q <= stb_d;
        end
    end
    assign reg_wr_stb = stb_q;

    // The read mux samples in the request cycle at either latency, so a same-cycle write is
    // never visible to the read (read-before-write); the pipe only delays the result.
    always_comb begin
        rd_off    = set_rd_addr - BASE_ADDR;
        rd_in_win = in_window(32'(set_rd_addr), 32'(BASE_ADDR), NREG);
        rd_mux    = '0;
        for (int k = 0; k < NREG; k++) begin
            if (rd_in_win && (rd_off == AW'(k))) begin
                rd_mux = rd_val[k];
            end
        end
    end

    jet_reg_rd_pipe #(
        .DW  (DW),
        .LAT (RD_LAT)
    ) u_rd_pipe (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .valid_i (set_rd_en),
        .data_i  (rd_mux),
        .err_i   (!rd_in_win),
        .valid_o (set_rd_data_en),
        .data_o  (set_rd_data),
        .err_o   (set_rd_err)
    );

endmodule

// File: tb/tb_jet_reg_bank.sv
// tb_jet_reg_bank: two banks (RD_LAT=1 and RD_LAT=2) driven in lockstep with the same
// stimulus; read results are predicted into per-bank queues and checked on return.
module tb_jet_reg_bank;

`ifdef JET_REG_BANK_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif
    localparam logic [7:0]   RO  = 8'h01;
    localparam logic [7:0]   PU  = 8'h02;
    localparam logic [127:0] RST = 128'h00A5 << 32;

    typedef struct {
        logic [15:0] data;
        logic        err;
        int          due;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_i = 1'b1;
    logic         set_wr_en = 1'b0;
    logic [15:0]  set_wr_addr = '0;
    logic [15:0]  set_wr_data = '0;
    logic         set_rd_en = 1'b0;
    logic [15:0]  set_rd_addr = '0;
    logic [127:0] ro_din = '0;
    logic         commit = 1'b0;

    logic [15:0]  a_data, b_data;
    logic         a_en, b_en, a_err, b_err;
    logic [127:0] a_regq, b_regq;
    logic [7:0]   a_stb, b_stb;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ma, mb;
    logic [15:0] sh[8];
    logic [15:0] act[8];
    logic [127:0] rstv = RST;
    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    jet_reg_bank #(
        .RD_LAT (1), .RO_MASK (RO), .PULSE_MASK (PU), .RST_VAL (RST)
    ) u_dut_a (
        .clk_i (clk), .reset_i (reset_i),
        .set_wr_en (set_wr_en), .set_wr_addr (set_wr_addr), .set_wr_data (set_wr_data),
        .set_rd_en (set_rd_en), .set_rd_addr (set_rd_addr),
        .set_rd_data (a_data), .set_rd_data_en (a_en), .set_rd_err (a_err),
        .reg_q (a_regq), .reg_wr_stb (a_stb), .ro_din (ro_din), .commit_i (commit)
    );

    jet_reg_bank #(
        .RD_LAT (2), .RO_MASK (RO), .PULSE_MASK (PU), .RST_VAL (RST)
    ) u_dut_b (
        .clk_i (clk), .reset_i (reset_i),
        .set_wr_en (set_wr_en), .set_wr_addr (set_wr_addr), .set_wr_data (set_wr_data),
        .set_rd_en (set_rd_en), .set_rd_addr (set_rd_addr),
        .set_rd_data (b_data), .set_rd_data_en (b_en), .set_rd_err (b_err),
        .reg_q (b_regq), .reg_wr_stb (b_stb), .ro_din (ro_din), .commit_i (commit)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int idx_of(input logic [15:0] a);
        if (a >= 16'h0010 && a <= 16'h0017) return int'(a) - 16;
        return -1;
    endfunction

    function automatic logic [15:0] rdv(input int k);
        if (RO[k]) return ro_din[k*16 +: 16];
        if (PU[k]) return act[k];
        return sh[k];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 8; k++) begin
            act[k] = rstv[k*16 +: 16];
            sh[k]  = act[k];
        end
    endtask

    task automatic chk_regs(input string tag);
        logic [15:0] e;
        for (int k = 0; k < 8; k++) begin
            e = RO[k] ? ro_din[k*16 +: 16] : act[k];
            chk($sformatf("%s_regqA%0d", tag, k), a_regq[k*16 +: 16], e);
            chk($sformatf("%s_regqB%0d", tag, k), b_regq[k*16 +: 16], e);
        end
    endtask

    // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
    task automatic step(input string tag, input bit we, input logic [15:0] wa,
                        input logic [15:0] wd, input bit re, input logic [15:0] ra,
                        input bit cm);
        exp_t e;
        logic [7:0] stbx;
        int ri, wi;
        set_wr_en = we; set_wr_addr = wa; set_wr_data = wd;
        set_rd_en = re; set_rd_addr = ra; commit = cm;
        if (re) begin
            ri = idx_of(ra);
            e.err  = (ri < 0);
            e.data = (ri < 0) ? 16'h0000 : rdv(ri);
            e.due  = cyc + 1;
            qa.push_back(e);
            e.due  = cyc + 2;
            qb.push_back(e);
        end
        stbx = '0;
        for (int k = 0; k < 8; k++) begin
            if (PU[k]) begin
                act[k] = rstv[k*16 +: 16];
                sh[k]  = act[k];
            end
        end
        wi = we ? idx_of(wa) : -1;
        if (wi >= 0 && !RO[wi]) begin
            if (PU[wi]) begin
                act[wi] = wd; sh[wi] = wd; stbx[wi] = 1'b1;
            end else begin
                sh[wi] = wd;
                if (!SHADOW) begin
                    act[wi] = wd; stbx[wi] = 1'b1;
                end
            end
        end
        if (SHADOW && cm) begin
            for (int k = 0; k < 8; k++) begin
                if (!RO[k] && !PU[k]) begin
                    if (sh[k] != act[k]) stbx[k] = 1'b1;
                    act[k] = sh[k];
                end
            end
        end
        @(posedge clk);
        #1;
        set_wr_en = 1'b0; set_rd_en = 1'b0; commit = 1'b0;
        chk({tag, "_stbA"}, a_stb, stbx);
        chk({tag, "_stbB"}, b_stb, stbx);
        chk_regs(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0);
    endtask

    // Read returns: every valid must match the oldest prediction, on its due cycle.
    always @(negedge clk) begin
        if (a_en === 1'b1) begin
            if (qa.size() == 0) begin
                chk("rdA_unsolicited", a_en, 0);
            end else begin
                ma = qa.pop_front();
                chk("rdA_cycle", cyc, ma.due);
                chk("rdA_data", a_data, ma.data);
                chk("rdA_err", a_err, ma.err);
            end
        end
        if (b_en === 1'b1) begin
            if (qb.size() == 0) begin
                chk("rdB_unsolicited", b_en, 0);
            end else begin
                mb = qb.pop_front();
                chk("rdB_cycle", cyc, mb.due);
                chk("rdB_data", b_data, mb.data);
                chk("rdB_err", b_err, mb.err);
            end
        end
    end

    task automatic drain(input string tag);
        for (int i = 0; i < 8 && (qa.size() != 0 || qb.size() != 0); i++) idle(tag);
        chk({tag, "_pendA"}, qa.size(), 0);
        chk({tag, "_pendB"}, qb.size(), 0);
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_rdA", {a_en, a_err, a_data}, 0);
        chk("rst_rdB", {b_en, b_err, b_data}, 0);
        chk("rst_stbA", a_stb, 0);
        chk("rst_stbB", b_stb, 0);
        chk_regs("rst");
        @(posedge clk);
        #1;
        reset_i = 1'b0;

        // Reset values, eight back-to-back reads in order.
        for (int i = 0; i < 8; i++) step("rdall", 0, 0, 0, 1, 16'h0010 + 16'(i), 0);
        // Same-cycle read and write returns the old value, then the new one.
        step("wr13", 1, 16'h0013, 16'h1234, 1, 16'h0013, 0);
        step("rd13", 0, 0, 0, 1, 16'h0013, 0);
        // Read-only register ignores writes and reflects ro_din.
        ro_din[15:0] = 16'hBEEF;
        step("wrro", 1, 16'h0010, 16'h0000, 0, 0, 0);
        step("rdro", 0, 0, 0, 1, 16'h0010, 0);
        // Out-of-window addresses on both sides, and a write that must be dropped.
        step("rdlo", 1, 16'h0018, 16'h7777, 1, 16'h000F, 0);
        step("rdhi", 1, 16'h000F, 16'h6666, 1, 16'h0018, 0);
        step("rdtop", 0, 0, 0, 1, 16'hFFFF, 0);
        // Pulse register: one-cycle load, back-to-back writes stay loaded.
        step("pul1", 1, 16'h0011, 16'h0001, 0, 0, 0);
        step("pul1z", 0, 0, 0, 1, 16'h0011, 0);
        step("pul2", 1, 16'h0011, 16'h0002, 0, 0, 0);
        step("pul3", 1, 16'h0011, 16'h0003, 1, 16'h0011, 0);
        idle("pulz");
        // Shadow behaviour (immediate update when shadows are not built).
        step("sh4", 1, 16'h0014, 16'h0055, 0, 0, 0);
        step("sh4rd", 0, 0, 0, 1, 16'h0014, 0);
        step("cm1", 0, 0, 0, 0, 0, 1);
        step("cm2", 1, 16'h0015, 16'h00AA, 1, 16'h0015, 1);
        step("cm3", 1, 16'h0013, 16'h4321, 0, 0, 0);
        step("cm4", 0, 0, 0, 1, 16'h0013, 1);
        drain("mid");

        // Reset with reads in flight: nothing may come back afterwards.
        step("inflt1", 0, 0, 0, 1, 16'h0012, 0);
        set_rd_en = 1'b1; set_rd_addr = 16'h0013;
        reset_i = 1'b1;
        qa.delete();
        qb.delete();
        model_reset();
        #1;
        chk("mrst_enA", a_en, 0);
        chk("mrst_enB", b_en, 0);
        set_rd_en = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        for (int i = 0; i < 4; i++) idle("postrst");
        step("rdpost", 0, 0, 0, 1, 16'h0012, 0);
        step("rdpost3", 0, 0, 0, 1, 16'h0013, 0);
        drain("end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
